serial_adder_ctrl: RTL and testbench

//   Sequencer that reuses a single 1-bit full-adder cell (fa) to add two WIDTH-bit

---
 rtl/serial_adder_ctrl_if.sv | 44 ++++
 rtl/serial_adder_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl_if
//  Description : Operand/result handshake bundle for the bit-serial adder
//                sequencer. The producer/consumer side uses the master
//                modport; the sequencer uses the slave modport.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    in_valid   producer -> ctrl   operand set on a/b/cin is valid
//    in_ready   ctrl -> producer   controller can accept operands
//    a, b       producer -> ctrl   WIDTH-bit operands
//    cin        producer -> ctrl   carry-in
//    out_valid  ctrl -> consumer   sum/cout hold a completed result
//    out_ready  consumer -> ctrl   consumer accepts the result
//    sum        ctrl -> consumer   low WIDTH bits of a+b+cin
//    cout       ctrl -> consumer   carry-out of a+b+cin
//    busy       ctrl -> observer   operation in progress or result pending
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_fa
//  Description : One-bit full-adder cell, the only arithmetic in the
//                serial adder.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    x, y, ci   in   addend bits and carry-in
//    s, co      out  sum bit and carry-out
// ============================================================================
module serial_adder_fa (
    input  wire logic x,
    input  wire logic y,
    input  wire logic ci,
    output logic      s,
    output logic      co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder sequencer. Captures two WIDTH-bit operands
//                and a carry-in on the input handshake, then adds them LSB
//                first through a single full-adder cell, one bit per clock,
//                and holds the result until the consumer accepts it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in      rising-edge clock
//    rst_n   in      asynchronous reset, active low
//    bus     slave   operand/result handshake bundle (serial_adder_ctrl_if)
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    // Holds the WIDTH-1 most recent sum bits; the newest bit from the adder
    // cell completes the word, so a full WIDTH-bit accumulator is not needed.
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_load;
    logic             w_last;

    serial_adder_fa u_fa (
        .x  (r_opa[0]),
        .y  (r_opb[0]),
        .ci (r_carry),
        .s  (w_fa_sum),
        .co (w_fa_cout)
    );

    assign w_acc_next = {w_fa_sum, r_acc};
    assign w_load     = (r_state == c_IDLE) && bus.in_valid;
    assign w_last     = (r_state == c_RUN) && (r_cnt == c_CNT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.in_valid)  w_state_next = c_RUN;
            c_RUN:   if (w_last)        w_state_next = c_DONE;
            c_DONE:  if (bus.out_ready) w_state_next = c_IDLE;
            default:                    w_state_next = c_IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            c_IDLE: bus.in_ready = 1'b1;
            c_RUN:  bus.busy     = 1'b1;
            c_DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- serial datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_opa   <= bus.a;
            r_opb   <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == c_RUN) begin
            r_carry <= w_fa_cout;
            r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
            r_acc   <= w_acc_next[WIDTH-1:1];
            r_cnt   <= r_cnt + c_CNT_ONE;
            // The visible result only moves on the final bit, so the
            // consumer never sees a partially accumulated sum.
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Self-checking bench for serial_adder_ctrl (WIDTH=8 and
//                WIDTH=2 instances). A transaction-level model of the 8-bit
//                instance is compared against the DUT every cycle; directed
//                scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction model of the 8-bit instance ----------------
    // Idle until an operand set is offered; the result appears WIDTH edges
    // after acceptance and stays until the consumer takes it.
    bit         m_idle;
    int         m_wait;
    logic [8:0] m_pend;
    logic [8:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_wait <= 0;
            m_res  <= '0;
        end else if (m_idle) begin
            if (bus8.in_valid) begin
                m_idle <= 1'b0;
                m_wait <= 8;
                m_pend <= 9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin);
            end
        end else if (m_wait > 1) begin
            m_wait <= m_wait - 1;
        end else if (m_wait == 1) begin
            m_wait <= 0;
            m_res  <= m_pend;
        end else if (bus8.out_ready) begin
            m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("mdl_in_ready",  32'(bus8.in_ready),  32'(m_idle));
        chk("mdl_out_valid", 32'(bus8.out_valid), 32'(!m_idle && m_wait == 0));
        chk("mdl_busy",      32'(bus8.busy),      32'(!m_idle));
        chk("mdl_sum",       32'(bus8.sum),       32'(m_res[7:0]));
        chk("mdl_cout",      32'(bus8.cout),      32'(m_res[8]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set (caller guarantees in_ready), then wait for the
    // result; lat counts edges from the handshake to out_valid.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, output int lat);
        bus8.a        = ta;
        bus8.b        = tb_v;
        bus8.cin      = tc;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        bus8.a        = ~ta;
        bus8.b        = ~tb_v;
        bus8.cin      = ~tc;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (lat >= 40) chk("op8_timeout", 32'(lat), 32'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [7:0]  ta [3];
        logic [7:0]  tbv[3];
        logic        tcv[3];
        time         t_acc[3];
        int          k;
        int          guard;
        logic        rdy;

        rst_n          = 1'b0;
        bus8.in_valid  = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b1;
        bus2.in_valid  = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(bus8.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_busy",      32'(bus8.busy),      32'd0);
        chk("rst_sum",       32'(bus8.sum),       32'd0);
        chk("rst_cout",      32'(bus8.cout),      32'd0);
        chk("rst2_in_ready", 32'(bus2.in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // 1: basic add, latency and one-cycle result with out_ready high
        op8(8'h5A, 8'h33, 1'b0, lat);
        chk("t1_latency", 32'(lat),       32'd8);
        chk("t1_sum",     32'(bus8.sum),  32'h8D);
        chk("t1_cout",    32'(bus8.cout), 32'd0);
        tick();
        chk("t1_valid_1cyc", 32'(bus8.out_valid), 32'd0);
        chk("t1_in_ready",   32'(bus8.in_ready),  32'd1);

        // 2: carry and zero cases
        op8(8'hFF, 8'h01, 1'b0, lat);
        chk("t2a_sum", 32'(bus8.sum), 32'h00);  chk("t2a_cout", 32'(bus8.cout), 32'd1);
        tick();
        op8(8'hFF, 8'hFF, 1'b1, lat);
        chk("t2b_sum", 32'(bus8.sum), 32'hFF);  chk("t2b_cout", 32'(bus8.cout), 32'd1);
        tick();
        op8(8'h00, 8'h00, 1'b0, lat);
        chk("t2c_sum", 32'(bus8.sum), 32'h00);  chk("t2c_cout", 32'(bus8.cout), 32'd0);
        tick();

        // 3: backpressure in DONE, in_valid pulse ignored
        bus8.out_ready = 1'b0;
        op8(8'h12, 8'h34, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin bus8.in_valid = 1'b1; bus8.a = 8'hEE; bus8.b = 8'h11; end
            if (i == 2) bus8.in_valid = 1'b0;
            tick();
            chk("t3_hold_valid", 32'(bus8.out_valid), 32'd1);
            chk("t3_hold_ready", 32'(bus8.in_ready),  32'd0);
            chk("t3_hold_sum",   32'(bus8.sum),       32'h47);
            chk("t3_hold_cout",  32'(bus8.cout),      32'd0);
        end
        bus8.out_ready = 1'b1;
        tick();
        chk("t3_release_ready", 32'(bus8.in_ready),  32'd1);
        chk("t3_release_valid", 32'(bus8.out_valid), 32'd0);
        chk("t3_idle_sum_kept", 32'(bus8.sum),       32'h47);

        // 4: asynchronous reset with cnt=3 during RUN
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_in_ready",  32'(bus8.in_ready),  32'd1);
        chk("t4_rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("t4_rst_busy",      32'(bus8.busy),      32'd0);
        chk("t4_rst_sum",       32'(bus8.sum),       32'd0);
        chk("t4_rst_cout",      32'(bus8.cout),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t4_post_in_ready", 32'(bus8.in_ready), 32'd1);
        op8(8'h10, 8'h20, 1'b1, lat);
        chk("t4_latency", 32'(lat),       32'd8);
        chk("t4_sum",     32'(bus8.sum),  32'h31);
        chk("t4_cout",    32'(bus8.cout), 32'd0);
        tick();

        // 5: in_valid held high across three queued operand sets
        ta[0] = 8'h01; tbv[0] = 8'h02; tcv[0] = 1'b0;
        ta[1] = 8'h80; tbv[1] = 8'h80; tcv[1] = 1'b1;
        ta[2] = 8'h7F; tbv[2] = 8'h01; tcv[2] = 1'b0;
        k = 0; guard = 0;
        bus8.a = ta[0]; bus8.b = tbv[0]; bus8.cin = tcv[0]; bus8.in_valid = 1'b1;
        while (k < 3 && guard < 100) begin
            rdy = bus8.in_ready;
            tick();
            guard++;
            if (rdy) begin
                t_acc[k] = $time;
                k++;
                if (k < 3) begin
                    bus8.a = ta[k]; bus8.b = tbv[k]; bus8.cin = tcv[k];
                end else begin
                    bus8.in_valid = 1'b0;
                end
            end
        end
        bus8.in_valid = 1'b0;
        chk("t5_accepts", 32'(k), 32'd3);
        if (k == 3) begin
            chk("t5_gap01", 32'((t_acc[1] - t_acc[0]) / 10), 32'd10);
            chk("t5_gap12", 32'((t_acc[2] - t_acc[1]) / 10), 32'd10);
        end
        guard = 0;
        while (bus8.out_valid !== 1'b1 && guard < 20) begin tick(); guard++; end
        chk("t5_last_sum",  32'(bus8.sum),  32'h80);
        chk("t5_last_cout", 32'(bus8.cout), 32'd0);
        tick();

        // 6: WIDTH=2 exhaustive sweep
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    bus2.a = 2'(ia); bus2.b = 2'(ib); bus2.cin = 1'(ic);
                    bus2.in_valid = 1'b1;
                    tick();
                    bus2.in_valid = 1'b0;
                    lat = 0;
                    while (bus2.out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
                    chk($sformatf("t6_lat_%0d_%0d_%0d", ia, ib, ic), 32'(lat), 32'd2);
                    chk($sformatf("t6_sum_%0d_%0d_%0d", ia, ib, ic),
                        32'({bus2.cout, bus2.sum}), 32'(ia + ib + ic));
                    tick();
                end
            end
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
